// File: rtl/ss_sg_arb_if.sv
// ---------------------------------------------------------------------------
// ss_sg_arb_if
//   One Wishbone link. The arbiter has three of these: two requesters
//   (m0 = src/read engine, m1 = dst/write engine) and the shared slave port.
//
//   Handshake: cyc frames a bus tenure. Within a tenure, stb marks a cycle
//   that offers a transfer (we/cab/sel/adr valid). The transfer ends in any
//   strobed cycle where the slave returns exactly one of ack (done), rty
//   (retry later) or err (failed). A strobed cycle with no response is a
//   stall and the master must hold its request unchanged.
//
//   Signals
//     cyc, stb, we, cab   master -> slave  cycle, strobe, write, burst flag
//     sel[3:0]            master -> slave  byte select
//     adr[31:0]           master -> slave  address
//     ack, rty, err       slave  -> master responses
// ---------------------------------------------------------------------------
interface ss_sg_arb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        cab;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic        ack;
    logic        rty;
    logic        err;

    modport master (
        output cyc, stb, we, cab, sel, adr,
        input  ack, rty, err
    );

    modport slave (
        input  cyc, stb, we, cab, sel, adr,
        output ack, rty, err
    );
endinterface

// File: rtl/ss_sg_arb.sv
// ---------------------------------------------------------------------------
// ss_sg_arb
//   Round-robin arbiter sharing one Wishbone master port between the two
//   SG engines. Grants whole tenures, preempts a long burst with a one-cycle
//   retry when the other engine is waiting, and turns a silent slave into a
//   one-cycle err to the owner (with a sticky flag and a lock that holds
//   until that engine drops cyc).
//
//   Ports
//     wb_clk_i      clock
//     wb_rst_n      asynchronous active-low reset
//     m0, m1        requester links (slave side of each engine's master)
//     s             shared master link towards the slave
//     gnt[1:0]      one-hot current owner, 00 when idle
//     to_err[1:0]   sticky watchdog flag per requester
//     to_clr        clears to_err; wins over a same-cycle set
//     dbg_state_o   current FSM state
//
//   Read data is wired from the slave to both engines outside this block.
// ---------------------------------------------------------------------------
module ss_sg_arb #(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    ss_sg_arb_if.slave  m0,
    ss_sg_arb_if.slave  m1,
    ss_sg_arb_if.master s,
    output logic [1:0]  gnt,
    output logic [1:0]  to_err,
    input  logic        to_clr,
    output logic [1:0]  dbg_state_o
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [7:0]    WDOG_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        RTY   = 2'd2,
        TOERR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [7:0]    wdog_q,  wdog_d;
    logic [1:0]    lock_q,  lock_d;
    logic [1:0]    to_err_q, to_err_d;

    logic [1:0] cyc_v;
    logic [1:0] stb_v;
    logic [1:0] elig;
    logic       other;
    logic       pick;
    logic       s_stb_w;
    logic       stall;
    logic [2:0] own_rsp;

    assign cyc_v = {m1.cyc, m0.cyc};
    assign stb_v = {m1.stb, m0.stb};
    assign elig  = cyc_v & ~lock_q;
    assign other = ~owner_q;

    // -----------------------------------------------------------------------
    // Slave-side mux. Everything is gated by state so the port is quiet in
    // IDLE/TOERR and drops with an asynchronous reset.
    // -----------------------------------------------------------------------
    assign s_stb_w = (state_q == OWN) & stb_v[owner_q];
    assign stall   = s_stb_w & ~(s.ack | s.rty | s.err);

    always_comb begin
        s.cyc = 1'b0;
        s.stb = 1'b0;
        s.we  = 1'b0;
        s.cab = 1'b0;
        s.sel = 4'h0;
        s.adr = 32'h0;
        if (state_q == OWN || state_q == RTY) begin
            s.we  = owner_q ? m1.we  : m0.we;
            s.cab = owner_q ? m1.cab : m0.cab;
            s.sel = owner_q ? m1.sel : m0.sel;
            s.adr = owner_q ? m1.adr : m0.adr;
            // The retry cycle keeps cyc up so the tenure is not torn down.
            s.cyc = (state_q == RTY) ? 1'b1 : cyc_v[owner_q];
            s.stb = s_stb_w;
        end
    end

    // -----------------------------------------------------------------------
    // Response routing: {ack, rty, err} for the owner. Slave responses pass
    // only in OWN; RTY and TOERR synthesise their own one-cycle response.
    // -----------------------------------------------------------------------
    always_comb begin
        own_rsp = 3'b000;
        case (state_q)
            OWN:     own_rsp = {s.ack, s.rty, s.err};
            RTY:     own_rsp = 3'b010;
            TOERR:   own_rsp = 3'b001;
            default: own_rsp = 3'b000;
        endcase
    end

    always_comb begin
        m0.ack = 1'b0;
        m0.rty = 1'b0;
        m0.err = 1'b0;
        m1.ack = 1'b0;
        m1.rty = 1'b0;
        m1.err = 1'b0;
        if (owner_q) begin
            {m1.ack, m1.rty, m1.err} = own_rsp;
        end else begin
            {m0.ack, m0.rty, m0.err} = own_rsp;
        end
    end

    assign gnt         = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign to_err      = to_err_q;
    assign dbg_state_o = state_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        to_err_d = to_err_q;
        pick     = 1'b0;
        // A lock only lasts until the engine ends its cycle.
        lock_d   = lock_q & cyc_v;

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    pick    = (elig == 2'b11) ? ~last_q : elig[1];
                    state_d = OWN;
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    wdog_d  = 8'd0;
                end
            end

            OWN, RTY: begin
                if (!cyc_v[owner_q]) begin
                    // Tenure ended: hand straight over if the other side waits.
                    cnt_d  = '0;
                    wdog_d = 8'd0;
                    if (elig[other]) begin
                        state_d = OWN;
                        owner_d = other;
                        last_d  = other;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == RTY) begin
                    // Owner ignored the retry: it keeps the bus for a fresh
                    // MAX_BURST acks.
                    state_d = OWN;
                    cnt_d   = '0;
                    wdog_d  = 8'd0;
                end else if (stall && wdog_q == WDOG_LAST) begin
                    state_d           = TOERR;
                    wdog_d            = 8'd0;
                    to_err_d[owner_q] = 1'b1;
                    lock_d[owner_q]   = 1'b1;
                end else begin
                    wdog_d = stall ? wdog_q + 8'd1 : 8'd0;
                    if (s.ack) begin
                        // The count parks at MAX_BURST-1, so an engine that
                        // bursted alone is cut at its next ack once the
                        // other engine turns up.
                        if (cnt_q == CNT_LAST) begin
                            if (elig[other]) begin
                                state_d = RTY;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            TOERR: begin
                state_d = IDLE;
                cnt_d   = '0;
                wdog_d  = 8'd0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (to_clr) begin
            to_err_d = 2'b00;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            wdog_q   <= 8'd0;
            lock_q   <= 2'b00;
            to_err_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            lock_q   <= lock_d;
            to_err_q <= to_err_d;
        end
    end

endmodule

// File: tb/tb_ss_sg_arb.sv
// ---------------------------------------------------------------------------
// tb_ss_sg_arb
//   Directed scenarios followed by random traffic, every cycle compared
//   against a tenure-level model of the arbiter.
// ---------------------------------------------------------------------------
module tb_ss_sg_arb;

  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 255;

  logic       clk;
  logic       rst_n;
  logic       to_clr;
  logic [1:0] gnt;
  logic [1:0] to_err;
  logic [1:0] dbg_state;

  ss_sg_arb_if m0_if ();
  ss_sg_arb_if m1_if ();
  ss_sg_arb_if s_if ();

  ss_sg_arb #(.MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .gnt         (gnt),
    .to_err      (to_err),
    .to_clr      (to_clr),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // stimulus state
  logic [1:0]  cyc_b, stb_b, we_b, cab_b;
  logic [3:0]  sel_b [2];
  logic [31:0] adr_b [2];
  logic        sack, srty, serr, clr;

  int errors = 0;
  int checks = 0;
  int ack0_n, rty0_n, ack1_n, err1_n;
  int r_sel;

  // reference model: who owns the bus, which special cycle (if any) is
  // in progress, and the running counts of acks and stalled strobes
  int         mo_own;     // -1 idle, else requester index
  int         mo_phase;   // 0 normal, 1 retry cycle, 2 timeout-error cycle
  int         mo_acks;
  int         mo_stalls;
  int         mo_last;
  logic [1:0] mo_lock;
  logic [1:0] mo_toerr;

  logic [1:0]  e_gnt;
  logic        e_scyc, e_sstb;
  logic [37:0] e_bus;
  logic [5:0]  e_rsp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    m0_if.cyc = cyc_b[0]; m0_if.stb = stb_b[0]; m0_if.we = we_b[0];
    m0_if.cab = cab_b[0]; m0_if.sel = sel_b[0]; m0_if.adr = adr_b[0];
    m1_if.cyc = cyc_b[1]; m1_if.stb = stb_b[1]; m1_if.we = we_b[1];
    m1_if.cab = cab_b[1]; m1_if.sel = sel_b[1]; m1_if.adr = adr_b[1];
    s_if.ack = sack; s_if.rty = srty; s_if.err = serr;
    to_clr = clr;
  endtask

  task automatic model_reset();
    mo_own = -1; mo_phase = 0; mo_acks = 0; mo_stalls = 0;
    mo_last = 1; mo_lock = 2'b00; mo_toerr = 2'b00;
  endtask

  task automatic model_grant(input int w);
    mo_own = w; mo_last = w; mo_phase = 0; mo_acks = 0; mo_stalls = 0;
  endtask

  task automatic model_outputs();
    logic [2:0] rsp;
    e_gnt = 2'b00; e_scyc = 1'b0; e_sstb = 1'b0; e_bus = '0; e_rsp = '0;
    rsp = 3'b000;
    if (mo_own >= 0) begin
      e_gnt = (mo_own == 0) ? 2'b01 : 2'b10;
      if (mo_phase != 2)
        e_bus = {we_b[mo_own], cab_b[mo_own], sel_b[mo_own], adr_b[mo_own]};
      if (mo_phase == 0) begin
        e_scyc = cyc_b[mo_own];
        e_sstb = stb_b[mo_own];
        rsp = {sack, srty, serr};
      end else if (mo_phase == 1) begin
        e_scyc = 1'b1;
        rsp = 3'b010;
      end else begin
        rsp = 3'b001;
      end
      if (mo_own == 0) e_rsp[2:0] = rsp;
      else             e_rsp[5:3] = rsp;
    end
  endtask

  task automatic model_update();
    logic [1:0] elig;
    int         oth;
    logic       stalled;
    elig = cyc_b & ~mo_lock;
    mo_lock = mo_lock & cyc_b;
    if (mo_own < 0) begin
      if (elig == 2'b11)  model_grant(1 - mo_last);
      else if (elig[0])   model_grant(0);
      else if (elig[1])   model_grant(1);
    end else if (mo_phase == 2) begin
      mo_own = -1; mo_phase = 0;
    end else begin
      oth = 1 - mo_own;
      if (!cyc_b[mo_own]) begin
        if (elig[oth]) model_grant(oth);
        else begin mo_own = -1; mo_phase = 0; end
      end else if (mo_phase == 1) begin
        mo_phase = 0; mo_acks = 0; mo_stalls = 0;
      end else begin
        stalled = stb_b[mo_own] && !(sack || srty || serr);
        if (stalled) begin
          mo_stalls++;
          if (mo_stalls == TIMEOUT) begin
            mo_phase = 2;
            mo_toerr[mo_own] = 1'b1;
            mo_lock[mo_own] = 1'b1;
          end
        end else begin
          mo_stalls = 0;
        end
        if (sack) begin
          mo_acks++;
          if (mo_acks >= MAX_BURST && elig[oth]) mo_phase = 1;
        end
      end
    end
    if (clr) mo_toerr = 2'b00;
  endtask

  // one clock: apply inputs, compare mid-cycle, then advance the model
  task automatic tick();
    drive();
    #3;
    model_outputs();
    check("ctl",
          64'({gnt, to_err, s_if.cyc, s_if.stb,
               m1_if.ack, m1_if.rty, m1_if.err, m0_if.ack, m0_if.rty, m0_if.err}),
          64'({e_gnt, mo_toerr, e_scyc, e_sstb, e_rsp}));
    check("bus", 64'({s_if.we, s_if.cab, s_if.sel, s_if.adr}), 64'(e_bus));
    if (m0_if.ack) ack0_n++;
    if (m0_if.rty) rty0_n++;
    if (m1_if.ack) ack1_n++;
    if (m1_if.err) err1_n++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_counts();
    ack0_n = 0; rty0_n = 0; ack1_n = 0; err1_n = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc_b = 2'b00; stb_b = 2'b00; we_b = 2'b10; cab_b = 2'b01;
    sel_b[0] = 4'hF; sel_b[1] = 4'h3;
    adr_b[0] = 32'h1000_0000; adr_b[1] = 32'h2000_0040;
    sack = 1'b0; srty = 1'b0; serr = 1'b0; clr = 1'b0;
    clear_counts();
    model_reset();
    drive();
    #1;
    check("reset_outputs",
          64'({gnt, to_err, dbg_state, s_if.cyc, s_if.stb, s_if.we, s_if.cab, s_if.sel, s_if.adr,
               m0_if.ack, m0_if.rty, m0_if.err, m1_if.ack, m1_if.rty, m1_if.err}),
          64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: simultaneous request, m0 first; direct handover to m1
    cyc_b = 2'b11;
    tick();
    check("t1_first_grant_m0", 64'(gnt), 64'(2'b01));
    cyc_b[0] = 1'b0;
    tick();
    check("t1_handover_m1", 64'(gnt), 64'(2'b10));
    cyc_b[1] = 1'b0;
    tick();
    check("t1_idle", 64'(gnt), 64'(2'b00));

    // 2: m0 alone, 40-ack burst, never preempted
    cyc_b[0] = 1'b1; stb_b[0] = 1'b1;
    tick();
    clear_counts();
    sack = 1'b1;
    repeat (40) tick();
    check("t2_acks", 64'(ack0_n), 64'd40);
    check("t2_no_rty", 64'(rty0_n), 64'd0);
    check("t2_gnt", 64'(gnt), 64'(2'b01));
    cyc_b[0] = 1'b0; stb_b[0] = 1'b0; sack = 1'b0;
    tick();

    // 3: m0 bursting with m1 waiting, retry after the 16th ack
    cyc_b[0] = 1'b1; stb_b[0] = 1'b1;
    tick();
    clear_counts();
    cyc_b[1] = 1'b1; sack = 1'b1;
    repeat (16) tick();
    check("t3_acks_before_rty", 64'(ack0_n), 64'd16);
    check("t3_rty", 64'(m0_if.rty), 64'd1);
    check("t3_stb_low", 64'(s_if.stb), 64'd0);
    cyc_b[0] = 1'b0; stb_b[0] = 1'b0; sack = 1'b0;
    tick();
    check("t3_gnt_m1", 64'(gnt), 64'(2'b10));

    // 4: m1 owns, slave silent -> timeout error, lock until cyc drops
    stb_b[1] = 1'b1;
    clear_counts();
    repeat (TIMEOUT) tick();
    check("t4_err", 64'(m1_if.err), 64'd1);
    check("t4_to_err", 64'(to_err), 64'(2'b10));
    check("t4_scyc_low", 64'(s_if.cyc), 64'd0);
    repeat (5) tick();
    check("t4_locked_no_gnt", 64'(gnt), 64'(2'b00));
    cyc_b[1] = 1'b0; stb_b[1] = 1'b0;
    tick();
    cyc_b[1] = 1'b1;
    tick();
    check("t4_regrant_m1", 64'(gnt), 64'(2'b10));

    // 5: ack on the limit cycle wins; to_clr beats a same-cycle set
    stb_b[1] = 1'b1;
    clear_counts();
    repeat (TIMEOUT - 1) tick();
    sack = 1'b1;
    tick();
    sack = 1'b0;
    check("t5_ack_delivered", 64'(ack1_n), 64'd1);
    check("t5_no_err", 64'(err1_n), 64'd0);
    check("t5_to_err_kept", 64'(to_err), 64'(2'b10));
    check("t5_still_owner", 64'(gnt), 64'(2'b10));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_to_clr", 64'(to_err), 64'(2'b00));
    repeat (TIMEOUT - 2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_beats_set", 64'(to_err), 64'(2'b00));
    check("t5_err_fired", 64'(m1_if.err), 64'd1);
    cyc_b[1] = 1'b0; stb_b[1] = 1'b0;
    repeat (2) tick();

    // 6: asynchronous reset mid-burst, m0 wins first afterwards
    cyc_b[1] = 1'b1;
    tick();
    cyc_b[0] = 1'b1; stb_b[0] = 1'b1; cyc_b[1] = 1'b0;
    tick();
    cyc_b[1] = 1'b1; stb_b[1] = 1'b1; stb_b[0] = 1'b1;
    tick();
    sack = 1'b1;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_reset",
          64'({gnt, to_err, s_if.cyc, s_if.stb, s_if.adr,
               m0_if.ack, m0_if.rty, m0_if.err, m1_if.ack, m1_if.rty, m1_if.err}),
          64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    sack = 1'b0;
    tick();
    check("t6_first_grant_m0", 64'(gnt), 64'(2'b01));

    // random traffic against the model
    cyc_b = 2'b00; stb_b = 2'b00;
    tick();
    tick();
    for (int i = 0; i < 2000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 31) == 0) cyc_b[n] = ~cyc_b[n];
        stb_b[n] = cyc_b[n] & ($urandom_range(0, 3) != 0);
        we_b[n]  = 1'($urandom_range(0, 1));
        cab_b[n] = 1'($urandom_range(0, 1));
        sel_b[n] = 4'($urandom_range(0, 15));
        adr_b[n] = $urandom;
      end
      clr = ($urandom_range(0, 63) == 0);
      sack = 1'b0; srty = 1'b0; serr = 1'b0;
      model_outputs();
      if (e_sstb) begin
        r_sel = int'($urandom_range(0, 15));
        if (r_sel < 10)       sack = 1'b1;
        else if (r_sel == 10) srty = 1'b1;
        else if (r_sel == 11) serr = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
